effect_gate_hyst: RTL

Parametrised noise gate with hysteresis, hold timer and optional fade-out release. It is the successor to the hard-threshold gate stage in the effects chain. It sits in the per-sample effect pipeline between the codec receive path and the downstream effects, using the same valid-pulse trigger in/out convention. Unlike the hard gate, it suppresses chatter on decaying notes: separate open/close thresholds, a programmable hold time and a gain ramp replace the instantaneous mute.

---
 rtl/effect_gate_hyst_if.sv | 23 ++
 rtl/effect_gate_hyst.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/effect_gate_hyst_if.sv
// Sample-stream bundle for effect_gate_hyst: per-sample strobe, controls and gated result.
interface effect_gate_hyst_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LVL_W  = 3
);
  logic                     i_valid;
  logic                     i_enable;
  logic        [LVL_W-1:0]  i_level;
  logic signed [DATA_W-1:0] i_data;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_valid;
  logic                     o_gate_open;

  modport master (
    output i_valid, i_enable, i_level, i_data,
    input  o_data, o_valid, o_gate_open
  );

  modport slave (
    input  i_valid, i_enable, i_level, i_data,
    output o_data, o_valid, o_gate_open
  );
endinterface

// File: rtl/effect_gate_hyst.sv
// Noise gate with open/close hysteresis and hold timer; one-cycle latency, no backpressure.
// Optional fade-out release ramp enabled by defining EFFECT_GATE_FADE_EN.
module effect_gate_hyst #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned LVL_W        = 3,
  parameter int unsigned THR_STEP     = 50,
  parameter int unsigned HYST         = 25,
  parameter int unsigned HOLD_SAMPLES = 480,
  parameter int unsigned GAIN_W       = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  effect_gate_hyst_if.slave bus
);

  localparam int unsigned THR_W  = 32;
  localparam int unsigned CNT_W  = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam int unsigned GAIN_BITS = GAIN_W + 1;

  localparam logic [GAIN_BITS-1:0] GAIN_FULL = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(HOLD_SAMPLES - 1);
  localparam logic [DATA_W-1:0]    DATA_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]    DATA_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPEN    = 2'd1,
`ifdef EFFECT_GATE_FADE_EN
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
`else
    ST_HOLD    = 2'd2
`endif
  } state_e;

  state_e                    state_q, state_d;
  logic [GAIN_BITS-1:0]      gain_q, gain_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  o_data_q, o_data_d;
  logic                      o_valid_q, o_valid_d;
  logic                      gate_open_q, gate_open_d;

  logic [DATA_W-1:0]         abs_c;
  logic [THR_W-1:0]          open_thr_c;
  logic [THR_W-1:0]          close_thr_c;
  logic                      loud_c;
  logic                      quiet_c;
  logic signed [DATA_W-1:0]  gated_c;

  // Magnitude with the most negative code clamped to the positive maximum.
  always_comb begin
    abs_c = bus.i_data;
    if (bus.i_data[DATA_W-1]) begin
      abs_c = (bus.i_data == DATA_MIN) ? DATA_MAX : DATA_W'(-bus.i_data);
    end
  end

  // Thresholds follow the live level; close threshold saturates at zero.
  always_comb begin
    open_thr_c  = THR_W'(bus.i_level) * THR_W'(THR_STEP);
    close_thr_c = (open_thr_c > THR_W'(HYST)) ? (open_thr_c - THR_W'(HYST)) : '0;
    loud_c      = (THR_W'(abs_c) >= open_thr_c);
    quiet_c     = (THR_W'(abs_c) <  close_thr_c);
  end

  // Gain applied to the current sample uses the gain produced by its own transition.
`ifdef EFFECT_GATE_FADE_EN
  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
  logic signed [PROD_W-1:0] data_x_c;
  logic signed [PROD_W-1:0] gain_x_c;
  logic signed [PROD_W-1:0] prod_c;

  always_comb begin
    data_x_c = PROD_W'(bus.i_data);
    gain_x_c = PROD_W'(gain_d);
    prod_c   = data_x_c * gain_x_c;
    gated_c  = DATA_W'(prod_c >>> GAIN_W);
  end
`else
  always_comb begin
    gated_c = (gain_d == '0) ? '0 : bus.i_data;
  end
`endif

  // Next-state and output computation; everything advances only on valid samples.
  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    cnt_d       = cnt_q;
    o_data_d    = o_data_q;
    gate_open_d = gate_open_q;
    o_valid_d   = bus.i_valid;

    if (bus.i_valid) begin
      if (!bus.i_enable) begin
        state_d = ST_CLOSED;
        gain_d  = '0;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          ST_CLOSED: begin
            if (loud_c) begin
              state_d = ST_OPEN;
              gain_d  = GAIN_FULL;
            end else begin
              gain_d  = '0;
            end
          end
          ST_OPEN: begin
            gain_d = GAIN_FULL;
            if (quiet_c) begin
              state_d = ST_HOLD;
              cnt_d   = CNT_LOAD;
            end
          end
          ST_HOLD: begin
            gain_d = GAIN_FULL;
            if (!quiet_c) begin
              state_d = ST_OPEN;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
`ifdef EFFECT_GATE_FADE_EN
              state_d = ST_RELEASE;
              gain_d  = GAIN_FULL - GAIN_BITS'(1);
`else
              state_d = ST_CLOSED;
              gain_d  = '0;
`endif
            end
          end
`ifdef EFFECT_GATE_FADE_EN
          ST_RELEASE: begin
            if (loud_c) begin
              state_d = ST_OPEN;
              gain_d  = GAIN_FULL;
            end else begin
              gain_d = gain_q - GAIN_BITS'(1);
              if (gain_q == GAIN_BITS'(1)) begin
                state_d = ST_CLOSED;
              end
            end
          end
`endif
          default: begin
            state_d = ST_CLOSED;
            gain_d  = '0;
            cnt_d   = '0;
          end
        endcase
      end

      o_data_d    = bus.i_enable ? gated_c : bus.i_data;
      gate_open_d = (state_d != ST_CLOSED);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_CLOSED;
      gain_q      <= '0;
      cnt_q       <= '0;
      o_data_q    <= '0;
      o_valid_q   <= 1'b0;
      gate_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      cnt_q       <= cnt_d;
      o_data_q    <= o_data_d;
      o_valid_q   <= o_valid_d;
      gate_open_q <= gate_open_d;
    end
  end

  assign bus.o_data      = o_data_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_gate_open = gate_open_q;

endmodule
